io_port_ctrl: RTL and testbench

- Memory-mapped, multi-channel I/O controller between the CPU data bus and external peripherals.
- Each channel has a receive FIFO (peripheral to CPU, read via DIR), a transmit FIFO (CPU to peripheral, written via DOR), a status register SR and a control register CR.
- Peripheral side uses valid/ready handshakes per channel, replacing the single-register, ready-level interface of the previous generation.

---
 rtl/io_port_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_io_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
// Memory-mapped, multi-channel I/O controller sitting between the CPU data
// bus and external peripherals. Each channel owns a receive FIFO (peripheral
// to CPU, drained through DIR), a transmit FIFO (CPU to peripheral, filled
// through DOR), a status register SR and a control register CR.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   sel        bus access strobe (one access per cycle)
//   we         1 = write, 0 = read, qualified by sel
//   addr       [CH_W+1:2] channel, [1:0] register (0 DIR, 1 DOR, 2 SR, 3 CR)
//   wdata      bus write data
//   rdata      registered bus read data
//   in_valid   per-channel peripheral input valid
//   in_data    per-channel input data, channel c at [c*DATA_W +: DATA_W]
//   in_ready   per-channel receive FIFO can accept
//   out_valid  per-channel transmit data available
//   out_data   per-channel transmit FIFO head
//   out_ready  per-channel peripheral consumes out_data
//   irq        registered interrupt request
module io_port_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CH_W    = 1,
    parameter int DEPTH_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sel,
    input  logic                           we,
    input  logic [CH_W+1:0]                addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata,
    input  logic [(2**CH_W)-1:0]           in_valid,
    input  logic [(2**CH_W)*DATA_W-1:0]    in_data,
    output logic [(2**CH_W)-1:0]           in_ready,
    output logic [(2**CH_W)-1:0]           out_valid,
    output logic [(2**CH_W)*DATA_W-1:0]    out_data,
    input  logic [(2**CH_W)-1:0]           out_ready,
    output logic                           irq
);

    localparam int CH    = 2**CH_W;
    localparam int DEPTH = 2**DEPTH_W;
    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

    localparam logic [1:0] REG_DIR = 2'd0;
    localparam logic [1:0] REG_DOR = 2'd1;
    localparam logic [1:0] REG_SR  = 2'd2;
    localparam logic [1:0] REG_CR  = 2'd3;

    logic [CH_W-1:0]   acc_ch;
    logic [1:0]        acc_reg;
    logic              rd_acc;
    logic              wr_acc;

    logic [DATA_W-1:0] rx_head [CH];
    logic [DATA_W-1:0] sr_val  [CH];
    logic [DATA_W-1:0] cr_val  [CH];
    logic [CH-1:0]     rx_empty_v;
    logic [CH-1:0]     irq_src;

    // Only wdata[3:0] carry meaning for SR/CR writes; the upper bits are
    // only consumed by the DOR path, which uses the whole word anyway.
    logic unused_wdata_bits;
    assign unused_wdata_bits = ^wdata[DATA_W-1:4];

    assign acc_ch  = addr[CH_W+1:2];
    assign acc_reg = addr[1:0];
    assign rd_acc  = sel & ~we;
    assign wr_acc  = sel & we;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic              hit;
        logic [DATA_W-1:0] rx_mem [DEPTH];
        logic [DATA_W-1:0] tx_mem [DEPTH];
        logic [DEPTH_W-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
        logic [DEPTH_W:0]  rx_cnt, tx_cnt;
        logic              rx_en, tx_en, rx_ie, rx_uf, tx_of;
        logic              rx_full, rx_empty, tx_full, tx_empty;
        logic              rx_push, rx_pop, uf_set, uf_clr;
        logic              dor_wr, tx_push, tx_pop, of_set, of_clr;
        logic              dir_rd, sr_wr, cr_wr, flush;

        assign hit      = (acc_ch == CH_W'(c));
        assign rx_full  = (rx_cnt == FULL_CNT);
        assign rx_empty = (rx_cnt == '0);
        assign tx_full  = (tx_cnt == FULL_CNT);
        assign tx_empty = (tx_cnt == '0);

        assign dir_rd = rd_acc & hit & (acc_reg == REG_DIR);
        assign dor_wr = wr_acc & hit & (acc_reg == REG_DOR);
        assign sr_wr  = wr_acc & hit & (acc_reg == REG_SR);
        assign cr_wr  = wr_acc & hit & (acc_reg == REG_CR);

        // in_ready comes purely from registered state, so a full FIFO never
        // accepts a word even if a DIR read frees a slot in the same cycle.
        assign in_ready[c] = rx_en & ~rx_full;
        assign rx_push     = in_valid[c] & in_ready[c];
        assign rx_pop      = dir_rd & ~rx_empty;
        assign uf_set      = dir_rd & rx_empty;
        assign uf_clr      = sr_wr & wdata[2];

        // Full is judged on the pre-edge count, so a device pop in the same
        // cycle cannot rescue a DOR write into a full FIFO.
        assign tx_push      = dor_wr & ~tx_full;
        assign of_set       = dor_wr & tx_full;
        assign of_clr       = sr_wr & wdata[3];
        assign out_valid[c] = tx_en & ~tx_empty;
        assign tx_pop       = out_valid[c] & out_ready[c];
        assign flush        = cr_wr & wdata[2];

        assign out_data[c*DATA_W +: DATA_W] = tx_mem[tx_rptr];
        assign rx_head[c]    = rx_mem[rx_rptr];
        assign rx_empty_v[c] = rx_empty;
        assign sr_val[c]     = DATA_W'({8'h00, 8'(tx_cnt), 8'(rx_cnt),
                                        4'h0, tx_of, rx_uf, ~tx_full, ~rx_empty});
        assign cr_val[c]     = DATA_W'({rx_ie, 1'b0, tx_en, rx_en});
        assign irq_src[c]    = (rx_ie & ~rx_empty) | rx_uf | tx_of;

        // Receive FIFO storage; contents need no reset because the pointers
        // and count define which entries are live.
        always_ff @(posedge clk) begin
            if (rx_push) begin
                rx_mem[rx_wptr] <= in_data[c*DATA_W +: DATA_W];
            end
        end

        // Receive FIFO bookkeeping: a simultaneous push and pop moves both
        // pointers and leaves the count unchanged.
        always_ff @(posedge clk) begin
            if (rst) begin
                rx_wptr <= '0;
                rx_rptr <= '0;
                rx_cnt  <= '0;
            end else begin
                if (rx_push) begin
                    rx_wptr <= rx_wptr + 1'b1;
                end
                if (rx_pop) begin
                    rx_rptr <= rx_rptr + 1'b1;
                end
                case ({rx_push, rx_pop})
                    2'b10:   rx_cnt <= rx_cnt + 1'b1;
                    2'b01:   rx_cnt <= rx_cnt - 1'b1;
                    default: rx_cnt <= rx_cnt;
                endcase
            end
        end

        // Transmit FIFO storage, written from the bus through DOR.
        always_ff @(posedge clk) begin
            if (tx_push) begin
                tx_mem[tx_wptr] <= wdata;
            end
        end

        // Transmit FIFO bookkeeping: a flush outranks any push or pop in the
        // same cycle and leaves the FIFO empty.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                tx_wptr <= '0;
                tx_rptr <= '0;
                tx_cnt  <= '0;
            end else begin
                if (tx_push) begin
                    tx_wptr <= tx_wptr + 1'b1;
                end
                if (tx_pop) begin
                    tx_rptr <= tx_rptr + 1'b1;
                end
                case ({tx_push, tx_pop})
                    2'b10:   tx_cnt <= tx_cnt + 1'b1;
                    2'b01:   tx_cnt <= tx_cnt - 1'b1;
                    default: tx_cnt <= tx_cnt;
                endcase
            end
        end

        // Control bits and sticky error flags. A flag being set in the same
        // cycle software clears it stays set so no event is lost.
        always_ff @(posedge clk) begin
            if (rst) begin
                rx_en <= 1'b1;
                tx_en <= 1'b1;
                rx_ie <= 1'b0;
                rx_uf <= 1'b0;
                tx_of <= 1'b0;
            end else begin
                if (cr_wr) begin
                    rx_en <= wdata[0];
                    tx_en <= wdata[1];
                    rx_ie <= wdata[3];
                end
                if (uf_set) begin
                    rx_uf <= 1'b1;
                end else if (uf_clr) begin
                    rx_uf <= 1'b0;
                end
                if (of_set) begin
                    tx_of <= 1'b1;
                end else if (of_clr) begin
                    tx_of <= 1'b0;
                end
            end
        end
    end

    // Registered read port: DIR returns the head (or 0 when empty), DOR
    // always reads 0, SR/CR return their current value. Without sel the
    // last read value is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_acc) begin
            case (acc_reg)
                REG_DIR: rdata <= rx_empty_v[acc_ch] ? '0 : rx_head[acc_ch];
                REG_DOR: rdata <= '0;
                REG_SR:  rdata <= sr_val[acc_ch];
                default: rdata <= cr_val[acc_ch];
            endcase
        end
    end

    // Interrupt is the registered OR of every channel's request sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |irq_src;
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl
// Self-checking bench for io_port_ctrl (default parameters: 2 channels,
// 4-entry FIFOs, 32-bit data). Bus reads push their expected rdata onto a
// scoreboard queue that a monitor pops one cycle later; transmit words
// written through DOR are queued and popped when the channel 0 handshake
// completes.
module tb_io_port_ctrl;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  in_valid;
    logic [63:0] in_data;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_ready;
    logic        irq;

    int test_count = 0;
    int fail_count = 0;

    logic [31:0] rd_q [$];
    logic [31:0] tx_q [$];

    io_port_ctrl #(.DATA_W(32), .CH_W(1), .DEPTH_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .irq       (irq)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one peripheral input lane.
    task automatic setIn(input int ch, input logic v, input logic [31:0] d);
        in_valid[ch]          = v;
        in_data[ch*32 +: 32]  = d;
    endtask

    // One-cycle bus write; called and returns on a falling edge.
    task automatic busWrite(input int ch, input int r, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = {ch[0], r[1:0]};
        wdata = d;
        @(negedge clk);
        sel   = 1'b0;
        we    = 1'b0;
    endtask

    // One-cycle bus read; the expected rdata goes to the scoreboard.
    task automatic applyStimulus(input int ch, input int r, input logic [31:0] exp);
        rd_q.push_back(exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = {ch[0], r[1:0]};
        @(negedge clk);
        sel  = 1'b0;
    endtask

    // Read monitor: a read seen mid-cycle is checked just after the edge
    // that registers rdata.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && sel && !we) begin
                @(posedge clk);
                #1;
                checkOutput("rd_q_size", rd_q.size(), 1);
                if (rd_q.size() > 0) begin
                    checkOutput($sformatf("rdata_addr%0d", addr), rdata, rd_q.pop_front());
                end
            end
        end
    end

    // Transmit monitor for channel 0: each completed handshake must carry
    // the oldest outstanding DOR word.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid[0] && out_ready[0]) begin
                checkOutput("tx_q_size", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) begin
                    checkOutput("out_data0", out_data[31:0], tx_q.pop_front());
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        in_valid = '0; in_data = '0; out_ready = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_irq", irq, 0);
        checkOutput("reset_in_ready", in_ready, 2'b11);
        checkOutput("reset_out_valid", out_valid, 2'b00);
        @(negedge clk);
        applyStimulus(0, 2, 32'h0000_0002);
        applyStimulus(0, 3, 32'h0000_0003);

        // Two words into channel 1, drained in order.
        setIn(1, 1'b1, 32'hA1);
        @(negedge clk);
        setIn(1, 1'b1, 32'hB2);
        @(negedge clk);
        setIn(1, 1'b0, 32'h0);
        applyStimulus(1, 2, 32'h0000_0203);
        applyStimulus(1, 0, 32'hA1);
        applyStimulus(1, 2, 32'h0000_0103);
        applyStimulus(1, 0, 32'hB2);
        applyStimulus(1, 2, 32'h0000_0002);

        // Fill channel 0 receive FIFO, then one more that must be refused.
        for (int i = 0; i < 4; i++) begin
            setIn(0, 1'b1, 32'h100 + i);
            #2;
            checkOutput("fill_in_ready", in_ready[0], 1);
            @(negedge clk);
        end
        setIn(0, 1'b1, 32'h999);
        #2;
        checkOutput("full_in_ready", in_ready[0], 0);
        @(negedge clk);
        setIn(0, 1'b0, 32'h0);
        applyStimulus(0, 2, 32'h0000_0403);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 32'h100 + i);
        end
        applyStimulus(0, 0, 32'h0);
        applyStimulus(0, 2, 32'h0000_0006);
        checkOutput("uf_irq", irq, 1);
        busWrite(0, 2, 32'h4);
        applyStimulus(0, 2, 32'h0000_0002);
        checkOutput("uf_clr_irq", irq, 0);

        // Push and pop in the same cycle, then underflow with a push.
        setIn(0, 1'b1, 32'h5);
        @(negedge clk);
        setIn(0, 1'b1, 32'h6);
        applyStimulus(0, 0, 32'h5);
        setIn(0, 1'b0, 32'h0);
        applyStimulus(0, 2, 32'h0000_0103);
        applyStimulus(0, 0, 32'h6);
        setIn(0, 1'b1, 32'h7);
        applyStimulus(0, 0, 32'h0);
        setIn(0, 1'b0, 32'h0);
        applyStimulus(0, 2, 32'h0000_0107);
        applyStimulus(0, 0, 32'h7);
        busWrite(0, 2, 32'h4);

        // Transmit FIFO overflow, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) tx_q.push_back(32'h11 * i);
            busWrite(0, 1, 32'h11 * i);
        end
        applyStimulus(0, 2, 32'h0004_0008);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checkOutput("drain_out_valid", out_valid[0], 1);
            @(negedge clk);
        end
        #2;
        checkOutput("drained_out_valid", out_valid[0], 0);
        out_ready[0] = 1'b0;
        @(negedge clk);
        busWrite(0, 2, 32'h8);
        applyStimulus(0, 2, 32'h0000_0002);

        // Flush with data pending; flush bit reads back 0.
        busWrite(0, 1, 32'hAA);
        busWrite(0, 1, 32'hBB);
        #2;
        checkOutput("preflush_out_valid", out_valid[0], 1);
        @(negedge clk);
        busWrite(0, 3, 32'hF);
        #2;
        checkOutput("flush_out_valid", out_valid[0], 0);
        @(negedge clk);
        applyStimulus(0, 2, 32'h0000_0002);
        applyStimulus(0, 3, 32'h0000_000B);

        // tx_en=0 holds data; re-enabling releases it.
        busWrite(0, 3, 32'h1);
        busWrite(0, 1, 32'hCC);
        #2;
        checkOutput("txdis_out_valid", out_valid[0], 0);
        @(negedge clk);
        applyStimulus(0, 2, 32'h0001_0002);
        busWrite(0, 3, 32'h3);
        tx_q.push_back(32'hCC);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        #2;
        checkOutput("txen_drained", out_valid[0], 0);
        @(negedge clk);

        // Receive interrupt on channel 1.
        busWrite(1, 3, 32'hB);
        #2;
        checkOutput("ie_irq_idle", irq, 0);
        @(negedge clk);
        setIn(1, 1'b1, 32'h77);
        @(negedge clk);
        setIn(1, 1'b0, 32'h0);
        #2;
        checkOutput("ie_irq_push_edge", irq, 0);
        @(negedge clk);
        #2;
        checkOutput("ie_irq_set", irq, 1);
        @(negedge clk);
        applyStimulus(1, 0, 32'h77);
        #2;
        checkOutput("ie_irq_pop_edge", irq, 1);
        @(negedge clk);
        #2;
        checkOutput("ie_irq_clear", irq, 0);
        @(negedge clk);

        // Reset with FIFOs non-empty discards everything.
        setIn(1, 1'b1, 32'h88);
        setIn(0, 1'b1, 32'h99);
        @(negedge clk);
        setIn(1, 1'b0, 32'h0);
        setIn(0, 1'b0, 32'h0);
        busWrite(1, 1, 32'h12);
        #2;
        checkOutput("prereset_irq", irq, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("mid_reset_irq", irq, 0);
        checkOutput("mid_reset_rdata", rdata, 32'h0);
        checkOutput("mid_reset_in_ready", in_ready, 2'b11);
        checkOutput("mid_reset_out_valid", out_valid, 2'b00);
        @(negedge clk);
        applyStimulus(0, 2, 32'h0000_0002);
        applyStimulus(1, 2, 32'h0000_0002);
        applyStimulus(1, 3, 32'h0000_0003);

        @(negedge clk);
        checkOutput("rd_q_left", rd_q.size(), 0);
        checkOutput("tx_q_left", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
